// File: rtl/pipelined_add_sub_if.sv
// Stream bundle for the pipelined add/subtract unit: operands and control
// on the input side, result and flags on the output side.
interface pipelined_add_sub_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             SUB;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             OVF;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output A, B, Cin, SUB, in_valid, out_ready,
        input  in_ready, Sum, Cout, OVF, out_valid
    );

    modport slave (
        input  A, B, Cin, SUB, in_valid, out_ready,
        output in_ready, Sum, Cout, OVF, out_valid
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG_WIDTH-bit carry segment per
// register stage, valid/ready stream with a global stall, signed overflow flag.
module pipelined_add_sub #(
    parameter int WIDTH     = 16,
    parameter int SEG_WIDTH = 4,
    parameter int SATURATE  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_add_sub_if.slave bus
);
    localparam int NSEG = WIDTH / SEG_WIDTH;

    logic             advance;
    logic             carry0;
    logic [WIDTH-1:0] bEff;

    logic [WIDTH:0]   rawFull;
    logic             aMsb;
    logic             bMsb;
    logic             lastValid;
    logic             ovfRaw;
    logic [WIDTH-1:0] satValue;
    logic [WIDTH-1:0] sumNext;

    logic             validQ;
    logic             coutQ;
    logic             ovfQ;
    logic [WIDTH-1:0] sumQ;

    // Whole pipeline moves together; it only freezes when the output is held.
    assign advance      = bus.out_ready || !validQ;
    assign bus.in_ready = advance;

    assign bEff   = bus.SUB ? ~bus.B : bus.B;
    assign carry0 = bus.SUB ? ~bus.Cin : bus.Cin;

    generate
        if (NSEG == 1) begin : g_single
            assign rawFull   = {1'b0, bus.A} + {1'b0, bEff} + {{WIDTH{1'b0}}, carry0};
            assign aMsb      = bus.A[WIDTH-1];
            assign bMsb      = bEff[WIDTH-1];
            assign lastValid = bus.in_valid;
        end else begin : g_multi
            // Stage k resolves segment k; its operand registers keep only the
            // segments still to come and its sum register the ones already done.
            for (genvar k = 0; k < NSEG - 1; k++) begin : stage
                localparam int OPW  = WIDTH - (k + 1) * SEG_WIDTH;
                localparam int SUMW = (k + 1) * SEG_WIDTH;

                logic [SEG_WIDTH-1:0] aSeg;
                logic [SEG_WIDTH-1:0] bSeg;
                logic                 cIn;
                logic                 vIn;
                logic [OPW-1:0]       aNext;
                logic [OPW-1:0]       bNext;
                logic [SUMW-1:0]      sNext;
                logic [SEG_WIDTH:0]   segSum;

                logic                 vQ;
                logic                 cQ;
                logic [OPW-1:0]       aQ;
                logic [OPW-1:0]       bQ;
                logic [SUMW-1:0]      sQ;

                assign segSum = {1'b0, aSeg} + {1'b0, bSeg} + {{SEG_WIDTH{1'b0}}, cIn};

                if (k == 0) begin : g_src
                    assign aSeg  = bus.A[SEG_WIDTH-1:0];
                    assign bSeg  = bEff[SEG_WIDTH-1:0];
                    assign cIn   = carry0;
                    assign vIn   = bus.in_valid;
                    assign aNext = bus.A[WIDTH-1:SEG_WIDTH];
                    assign bNext = bEff[WIDTH-1:SEG_WIDTH];
                    assign sNext = segSum[SEG_WIDTH-1:0];
                end else begin : g_src
                    assign aSeg  = stage[k-1].aQ[SEG_WIDTH-1:0];
                    assign bSeg  = stage[k-1].bQ[SEG_WIDTH-1:0];
                    assign cIn   = stage[k-1].cQ;
                    assign vIn   = stage[k-1].vQ;
                    assign aNext = stage[k-1].aQ[WIDTH-k*SEG_WIDTH-1:SEG_WIDTH];
                    assign bNext = stage[k-1].bQ[WIDTH-k*SEG_WIDTH-1:SEG_WIDTH];
                    assign sNext = {segSum[SEG_WIDTH-1:0], stage[k-1].sQ};
                end

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        vQ <= 1'b0;
                        cQ <= 1'b0;
                        aQ <= '0;
                        bQ <= '0;
                        sQ <= '0;
                    end else if (advance) begin
                        vQ <= vIn;
                        cQ <= segSum[SEG_WIDTH];
                        aQ <= aNext;
                        bQ <= bNext;
                        sQ <= sNext;
                    end
                end
            end

            logic [SEG_WIDTH-1:0] aTop;
            logic [SEG_WIDTH-1:0] bTop;
            logic [SEG_WIDTH:0]   topSum;

            assign aTop      = stage[NSEG-2].aQ;
            assign bTop      = stage[NSEG-2].bQ;
            assign topSum    = {1'b0, aTop} + {1'b0, bTop} + {{SEG_WIDTH{1'b0}}, stage[NSEG-2].cQ};
            assign rawFull   = {topSum, stage[NSEG-2].sQ};
            assign aMsb      = aTop[SEG_WIDTH-1];
            assign bMsb      = bTop[SEG_WIDTH-1];
            assign lastValid = stage[NSEG-2].vQ;
        end
    endgenerate

    assign ovfRaw   = (aMsb == bMsb) && (rawFull[WIDTH-1] != aMsb);
    assign satValue = aMsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign sumNext  = ((SATURATE != 0) && ovfRaw) ? satValue : rawFull[WIDTH-1:0];

    // Final segment and flags land in the output register; flags stay raw.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            validQ <= 1'b0;
            sumQ   <= '0;
            coutQ  <= 1'b0;
            ovfQ   <= 1'b0;
        end else if (advance) begin
            validQ <= lastValid;
            sumQ   <= sumNext;
            coutQ  <= rawFull[WIDTH];
            ovfQ   <= ovfRaw;
        end
    end

    assign bus.out_valid = validQ;
    assign bus.Sum       = sumQ;
    assign bus.Cout      = coutQ;
    assign bus.OVF       = ovfQ;
endmodule
